// File: rtl/uart_tx_arbiter_if.sv
// Bundle between word producers, the round-robin arbiter and the uart_tx load handshake.
// master = producer/uart side, slave = arbiter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
);
  logic [N-1:0]    req_valid;
  logic [N*16-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [3:0]      cfg_width;
  logic [1:0]      cfg_parity;
  logic            tx_req_load;
  logic            tx_ack_load;
  logic [15:0]     tx_bits;
  logic [3:0]      tx_width;
  logic [1:0]      tx_parity;
  logic            busy;
  logic [IDW-1:0]  grant;

  modport master (
    output req_valid, req_data, cfg_width, cfg_parity, tx_req_load,
    input  req_ready, tx_ack_load, tx_bits, tx_width, tx_parity, busy, grant
  );

  modport slave (
    input  req_valid, req_data, cfg_width, cfg_parity, tx_req_load,
    output req_ready, tx_ack_load, tx_bits, tx_width, tx_parity, busy, grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serialiser between N word producers.
// Define UART_TX_ARBITER_PRIO0_EN to give port 0 strict priority over the rotation.
module uart_tx_arbiter #(
  parameter int unsigned N          = 4,
  parameter int unsigned IDW        = 2,
  parameter int unsigned GAP_CYCLES = 0
) (
  input logic              clock,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StBusy, StGap} state_e;

  state_e         state_q;
  logic [7:0]     gap_q;
  logic [N-1:0]   ready_q;
  logic           ack_q;
  logic           busy_q;
  logic [15:0]    bits_q;
  logic [3:0]     width_q;
  logic [1:0]     parity_q;
  logic [IDW-1:0] grant_q;

  logic [IDW-1:0] win;
  logic [IDW-1:0] idx;
  logic           found;
  logic           any_valid;

  assign any_valid = |bus.req_valid;

  // First valid port after the last grant, wrapping; modulo keeps N < 2**IDW in range.
  always_comb begin
    win   = grant_q;
    idx   = grant_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IDW'((32'(grant_q) + i) % N);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef UART_TX_ARBITER_PRIO0_EN
    if (bus.req_valid[0]) begin
      win = '0;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      gap_q    <= 8'd0;
      ready_q  <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      bits_q   <= 16'd0;
      width_q  <= 4'd8;
      parity_q <= 2'd0;
      grant_q  <= IDW'(N - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.tx_req_load && any_valid) begin
            bits_q   <= bus.req_data[{win, 4'b0000} +: 16];
            width_q  <= (bus.cfg_width == 4'd0) ? 4'd8 : bus.cfg_width;
            parity_q <= bus.cfg_parity;
            grant_q  <= win;
            ready_q  <= {{(N - 1){1'b0}}, 1'b1} << win;
            ack_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= StLoad;
          end
        end
        StLoad: begin
          ack_q   <= 1'b0;
          ready_q <= '0;
          state_q <= StBusy;
        end
        StBusy: begin
          // uart_tx raises req_load again only once the stop bit is on the line.
          if (bus.tx_req_load) begin
            if (GAP_CYCLES > 0) begin
              gap_q   <= 8'(GAP_CYCLES - 1);
              state_q <= StGap;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        StGap: begin
          if (gap_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.tx_ack_load = ack_q;
  assign bus.tx_bits     = bits_q;
  assign bus.tx_width    = width_q;
  assign bus.tx_parity   = parity_q;
  assign bus.busy        = busy_q;
  assign bus.grant       = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: producer queues, a uart_tx model and a
// cycle-count reference model of grant order, latched frame config and busy timing.
module tb_uart_tx_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned GAP = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;

  uart_tx_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  uart_tx_arbiter #(.N(N), .IDW(IDW), .GAP_CYCLES(GAP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus knobs and per-port word queues.
  logic [N-1:0] act_mask = '0;
  int           vprob    = 100;
  bit           cfg_rand = 1'b0;
  logic [3:0]   fix_w    = 4'd8;
  logic [1:0]   fix_p    = 2'd0;
  logic [15:0]  pq [N][$];

  // uart_tx model: req_load high when idle or while the stop bit is out.
  logic [19:0] u_sh  = '0;
  int          u_cnt = 0;
  logic        u_line;
  assign bus.tx_req_load = (u_cnt <= 1);
  assign u_line = (u_cnt > 0) ? u_sh[0] : 1'b1;

  function automatic logic [19:0] mk_frame(input logic [15:0] d, input logic [3:0] w,
                                           input logic [1:0] p);
    logic [19:0] f;
    int          pos;
    logic        par;
    f   = '0;
    pos = 1;
    par = p[0];
    for (int i = 0; i < int'(w); i++) begin
      f[pos] = d[i];
      par    = par ^ d[i];
      pos++;
    end
    if (p[1]) begin
      f[pos] = par;
      pos++;
    end
    f[pos] = 1'b1;
    return f;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      u_cnt <= 0;
      u_sh  <= '0;
    end else if (bus.tx_ack_load && bus.tx_req_load) begin
      u_sh  <= mk_frame(bus.tx_bits, bus.tx_width, bus.tx_parity);
      u_cnt <= 2 + int'(bus.tx_width) + int'(bus.tx_parity[1]);
    end else if (u_cnt > 0) begin
      u_sh  <= u_sh >> 1;
      u_cnt <= u_cnt - 1;
    end
  end

  // Producers: present queue head while valid; random valid drops lose nothing.
  always @(negedge clock) begin
    logic [N-1:0]    v;
    logic [N*16-1:0] d;
    for (int k = 0; k < N; k++) begin
      v[k] = act_mask[k] && (pq[k].size() > 0) && ($urandom_range(99) < vprob);
      d[16*k +: 16] = v[k] ? pq[k][0] : 16'($urandom);
    end
    bus.req_valid = v;
    bus.req_data  = d;
    if (cfg_rand) begin
      bus.cfg_width  = 4'($urandom_range(15));
      bus.cfg_parity = 2'($urandom_range(3));
    end else begin
      bus.cfg_width  = fix_w;
      bus.cfg_parity = fix_p;
    end
  end

  // Reference model: a grant at edge g blocks further grants until edge g+len+2+GAP,
  // where len = 2+width+parity_en; busy is low from edge g+len+1+GAP until the next grant.
  int          ecnt      = 0;
  int          m_next_ok = 0;
  int          m_last    = N - 1;
  int          nframes   = 0;
  logic [15:0] m_bits    = '0;
  logic [3:0]  m_w       = 4'd8;
  logic [1:0]  m_p       = 2'd0;
  int          glog[$];
  bit          sb_on     = 1'b0;
  logic [N-1:0] sb_v;
  logic [N-1:0] sb_ready;
  bit          sb_g;
  int          sb_w;

  function automatic int pick(input logic [N-1:0] v, input int last);
`ifdef UART_TX_ARBITER_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int s = 1; s <= N; s++) begin
      if (v[(last + s) % N]) return (last + s) % N;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    ecnt++;
    #1;
    if (reset && sb_on) begin
      sb_v     = bus.req_valid;
      sb_ready = '0;
      sb_g     = 1'b0;
      if (ecnt >= m_next_ok && sb_v != '0) begin
        sb_w           = pick(sb_v, m_last);
        sb_g           = 1'b1;
        sb_ready[sb_w] = 1'b1;
        m_last         = sb_w;
        m_bits         = pq[sb_w].pop_front();
        m_w            = (bus.cfg_width == 4'd0) ? 4'd8 : bus.cfg_width;
        m_p            = bus.cfg_parity;
        m_next_ok      = ecnt + 4 + int'(m_w) + int'(m_p[1]) + GAP;
        nframes++;
        glog.push_back(sb_w);
      end
      vectors += 7;
      if (bus.req_ready !== sb_ready) begin
        miscompares++;
        $display("FAIL req_ready edge %0d: got %b want %b", ecnt, bus.req_ready, sb_ready);
      end
      if (bus.tx_ack_load !== sb_g) begin
        miscompares++;
        $display("FAIL tx_ack_load edge %0d: got %b want %b", ecnt, bus.tx_ack_load, sb_g);
      end
      if (bus.busy !== (sb_g || (ecnt + 1 < m_next_ok))) begin
        miscompares++;
        $display("FAIL busy edge %0d: got %b want %b", ecnt, bus.busy,
                 sb_g || (ecnt + 1 < m_next_ok));
      end
      if (bus.grant !== IDW'(m_last)) begin
        miscompares++;
        $display("FAIL grant edge %0d: got %0d want %0d", ecnt, bus.grant, m_last);
      end
      if (bus.tx_bits !== m_bits) begin
        miscompares++;
        $display("FAIL tx_bits edge %0d: got %h want %h", ecnt, bus.tx_bits, m_bits);
      end
      if (bus.tx_width !== m_w) begin
        miscompares++;
        $display("FAIL tx_width edge %0d: got %0d want %0d", ecnt, bus.tx_width, m_w);
      end
      if (bus.tx_parity !== m_p) begin
        miscompares++;
        $display("FAIL tx_parity edge %0d: got %b want %b", ecnt, bus.tx_parity, m_p);
      end
    end
  end

  task automatic release_reset();
    @(negedge clock);
    m_last    = N - 1;
    m_bits    = '0;
    m_w       = 4'd8;
    m_p       = 2'd0;
    m_next_ok = ecnt + 1;
    reset     = 1'b1;
    sb_on     = 1'b1;
  endtask

  task automatic wait_frames(input int target);
    for (int c = 0; c < 4000 && nframes < target; c++) @(negedge clock);
    vectors++;
    if (nframes < target) begin
      miscompares++;
      $display("FAIL wait_frames: got %0d frames want %0d", nframes, target);
    end
  endtask

  task automatic wait_ack();
    int c;
    for (c = 0; c < 400; c++) begin
      @(negedge clock);
      if (bus.tx_ack_load === 1'b1) break;
    end
    vectors++;
    if (c == 400) begin
      miscompares++;
      $display("FAIL wait_ack: got no tx_ack_load want a pulse");
    end
  endtask

  task automatic drain();
    int tot;
    int c;
    act_mask = '1;
    vprob    = 100;
    for (c = 0; c < 5000; c++) begin
      @(negedge clock);
      tot = 0;
      for (int k = 0; k < N; k++) tot += pq[k].size();
      if (tot == 0 && ecnt + 1 >= m_next_ok) break;
    end
    vectors++;
    if (c == 5000) begin
      miscompares++;
      $display("FAIL drain: got pending work want idle");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    sb_on = 1'b0;
    repeat (3) @(negedge clock);
    vectors += 7;
    if (bus.tx_ack_load !== 1'b0) begin
      miscompares++; $display("FAIL reset ack: got %b want 0", bus.tx_ack_load);
    end
    if (bus.req_ready !== 4'b0000) begin
      miscompares++; $display("FAIL reset ready: got %b want 0000", bus.req_ready);
    end
    if (bus.tx_bits !== 16'h0000) begin
      miscompares++; $display("FAIL reset bits: got %h want 0000", bus.tx_bits);
    end
    if (bus.tx_width !== 4'd8) begin
      miscompares++; $display("FAIL reset width: got %0d want 8", bus.tx_width);
    end
    if (bus.tx_parity !== 2'b00) begin
      miscompares++; $display("FAIL reset parity: got %b want 00", bus.tx_parity);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL reset busy: got %b want 0", bus.busy);
    end
    if (bus.grant !== 2'd3) begin
      miscompares++; $display("FAIL reset grant: got %0d want 3", bus.grant);
    end
    release_reset();
  endtask

  task automatic test_all_valid();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    glog.delete();
    cfg_rand = 1'b1;
    for (int k = 0; k < N; k++) repeat (2) pq[k].push_back(16'($urandom));
    act_mask = '1;
    vprob    = 100;
    wait_frames(nframes + 5);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (glog.size() <= i || glog[i] != exp_seq[i]) begin
        miscompares++;
        $display("FAIL all_valid order[%0d]: got %0d want %0d", i,
                 (glog.size() > i) ? glog[i] : -1, exp_seq[i]);
      end
    end
    drain();
  endtask

  task automatic test_single_a5();
    logic [9:0] got;
    int         base;
    glog.delete();
    base     = nframes;
    cfg_rand = 1'b0;
    fix_w    = 4'd8;
    fix_p    = 2'd0;
    pq[0].push_back(16'h00A5);
    pq[0].push_back(16'h1234);
    act_mask = 4'b0001;
    wait_ack();
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++; $display("FAIL a5 ready: got %b want 0001", bus.req_ready);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      got[i] = u_line;
    end
    vectors++;
    if (got !== 10'b11_0100_1010) begin
      miscompares++; $display("FAIL a5 line: got %b want 1101001010", got);
    end
    wait_frames(base + 2);
    vectors++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 0) begin
      miscompares++; $display("FAIL single_port: got %0d grants want two to port 0", glog.size());
    end
    drain();
  endtask

  task automatic test_rotation_1_3();
    int exp_seq[5] = '{1, 3, 1, 3, 1};
    int base;
    glog.delete();
    base     = nframes;
    cfg_rand = 1'b1;
    pq[1].push_back(16'($urandom));
    act_mask = 4'b0010;
    wait_frames(base + 1);
    for (int i = 0; i < 2; i++) begin
      pq[1].push_back(16'($urandom));
      pq[3].push_back(16'($urandom));
    end
    act_mask = 4'b1010;
    wait_frames(base + 5);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (glog.size() <= i || glog[i] != exp_seq[i]) begin
        miscompares++;
        $display("FAIL rot13 order[%0d]: got %0d want %0d", i,
                 (glog.size() > i) ? glog[i] : -1, exp_seq[i]);
      end
    end
    drain();
  endtask

  task automatic test_width_change();
    int base;
    base     = nframes;
    cfg_rand = 1'b0;
    fix_w    = 4'd8;
    fix_p    = 2'd0;
    pq[0].push_back(16'h5A3C);
    pq[0].push_back(16'h00FF);
    act_mask = 4'b0001;
    wait_ack();
    fix_w = 4'd5;
    repeat (5) @(negedge clock);
    vectors++;
    if (bus.tx_width !== 4'd8) begin
      miscompares++; $display("FAIL width_mid: got %0d want 8", bus.tx_width);
    end
    wait_frames(base + 2);
    vectors++;
    if (bus.tx_width !== 4'd5) begin
      miscompares++; $display("FAIL width_next: got %0d want 5", bus.tx_width);
    end
    drain();
  endtask

  task automatic test_parity();
    logic [5:0] got;
    int         base;
    cfg_rand = 1'b0;
    fix_w    = 4'd3;
    fix_p    = 2'b11;
    pq[0].push_back(16'h0007);
    act_mask = 4'b0001;
    wait_ack();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      got[i] = u_line;
    end
    vectors++;
    if (got !== 6'b10_1110) begin
      miscompares++; $display("FAIL odd_parity line: got %b want 101110", got);
    end
    drain();
    base  = nframes;
    fix_w = 4'd0;
    fix_p = 2'b00;
    pq[0].push_back(16'h0081);
    act_mask = 4'b0001;
    wait_frames(base + 1);
    vectors++;
    if (bus.tx_width !== 4'd8) begin
      miscompares++; $display("FAIL width0: got %0d want 8", bus.tx_width);
    end
    drain();
  endtask

  task automatic test_random();
    cfg_rand = 1'b1;
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < N; k++) begin
        repeat ($urandom_range(3)) pq[k].push_back(16'($urandom));
      end
      act_mask = 4'($urandom);
      vprob    = $urandom_range(100, 30);
      repeat (40) @(negedge clock);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int base;
    cfg_rand = 1'b0;
    fix_w    = 4'd8;
    fix_p    = 2'd0;
    pq[0].push_back(16'hBEEF);
    act_mask = 4'b0001;
    wait_ack();
    repeat (3) @(negedge clock);
    @(posedge clock);
    #3;
    reset = 1'b0;
    sb_on = 1'b0;
    #1;
    vectors += 4;
    if (bus.tx_ack_load !== 1'b0) begin
      miscompares++; $display("FAIL midreset ack: got %b want 0", bus.tx_ack_load);
    end
    if (bus.busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset busy: got %b want 0", bus.busy);
    end
    if (bus.grant !== 2'd3) begin
      miscompares++; $display("FAIL midreset grant: got %0d want 3", bus.grant);
    end
    if (bus.tx_width !== 4'd8) begin
      miscompares++; $display("FAIL midreset width: got %0d want 8", bus.tx_width);
    end
    for (int k = 0; k < N; k++) pq[k].delete();
    glog.delete();
    repeat (2) @(negedge clock);
    release_reset();
    base = nframes;
    for (int k = 0; k < N; k++) pq[k].push_back(16'($urandom));
    act_mask = '1;
    wait_frames(base + 1);
    vectors++;
    if (glog.size() < 1 || glog[0] != 0) begin
      miscompares++;
      $display("FAIL post_reset first grant: got %0d want 0", (glog.size() > 0) ? glog[0] : -1);
    end
    drain();
  endtask

`ifdef UART_TX_ARBITER_PRIO0_EN
  task automatic test_prio0();
    int base;
    glog.delete();
    base     = nframes;
    cfg_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pq[0].push_back(16'($urandom));
      pq[2].push_back(16'($urandom));
    end
    act_mask = 4'b0101;
    vprob    = 100;
    wait_frames(base + 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (glog.size() <= i || glog[i] != 0) begin
        miscompares++;
        $display("FAIL prio0[%0d]: got %0d want 0", i, (glog.size() > i) ? glog[i] : -1);
      end
    end
    drain();
  endtask
`endif

  initial begin
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.cfg_width  = 4'd8;
    bus.cfg_parity = 2'd0;
    test_reset();
    test_all_valid();
    test_single_a5();
    test_rotation_1_3();
    test_width_change();
    test_parity();
    test_random();
    test_reset_mid();
`ifdef UART_TX_ARBITER_PRIO0_EN
    test_prio0();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
